// File: rtl/vga_timing_prog.sv
// Programmable VGA/DVI timing generator: live/shadow geometry swapped at frame
// boundaries, pix_en-qualified counters, registered sync/DE and a delayed tap.
module vga_timing_prog #(
  parameter int unsigned H_BITS     = 11,
  parameter int unsigned V_BITS     = 10,
  parameter int unsigned CFG_BITS   = 11,
  parameter int unsigned H_ACTIVE   = 800,
  parameter int unsigned H_FRONT    = 40,
  parameter int unsigned H_SYNC     = 128,
  parameter int unsigned H_BACK     = 88,
  parameter int unsigned V_ACTIVE   = 600,
  parameter int unsigned V_FRONT    = 1,
  parameter int unsigned V_SYNC     = 4,
  parameter int unsigned V_BACK     = 23,
  parameter logic        HSYNC_POL  = 1'b1,
  parameter logic        VSYNC_POL  = 1'b1,
  parameter int unsigned SYNC_DELAY = 2,
  parameter int unsigned FRAME_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pix_en,
  input  logic                  cfg_we,
  input  logic [2:0]            cfg_addr,
  input  logic [CFG_BITS-1:0]   cfg_data,
  output logic                  cfg_pending,
  output logic [H_BITS-1:0]     x,
  output logic [V_BITS-1:0]     y,
  output logic                  in_frame,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  line_start,
  output logic                  frame_start,
  output logic                  hsync_d,
  output logic                  vsync_d,
  output logic                  de_d,
  output logic [FRAME_BITS-1:0] frame_cnt
);

  localparam int unsigned HW = H_BITS + 1;
  localparam int unsigned VW = V_BITS + 1;
  localparam logic ACT_RST = (H_ACTIVE != 0) && (V_ACTIVE != 0);

  // Geometry sets, index 0..3 = active/front/sync/back
  logic [3:0][H_BITS-1:0] h_live_q, h_live_d, h_shd_q, h_shd_d;
  logic [3:0][V_BITS-1:0] v_live_q, v_live_d, v_shd_q, v_shd_d;

  logic [H_BITS-1:0]     hc_q, hc_d;
  logic [V_BITS-1:0]     vc_q, vc_d;
  logic                  cfg_pending_q, cfg_pending_d;
  logic [FRAME_BITS-1:0] frame_cnt_q, frame_cnt_d;

  logic [H_BITS-1:0] x_q, x_d;
  logic [V_BITS-1:0] y_q, y_d;
  logic act_q, act_d, hs_q, hs_d, vs_q, vs_d, ls_q, ls_d, fs_q, fs_d;

  logic [HW-1:0] h_total, h_sync_lo, h_sync_hi;
  logic [VW-1:0] v_total, v_sync_lo, v_sync_hi;
  logic          h_wrap, v_wrap, boundary;

  // Counter advance, frame-boundary geometry swap and config port
  always_comb begin
    h_live_d      = h_live_q;
    v_live_d      = v_live_q;
    h_shd_d       = h_shd_q;
    v_shd_d       = v_shd_q;
    hc_d          = hc_q;
    vc_d          = vc_q;
    cfg_pending_d = cfg_pending_q;
    frame_cnt_d   = frame_cnt_q;

    h_total = HW'(h_live_q[0]) + HW'(h_live_q[1]) + HW'(h_live_q[2]) + HW'(h_live_q[3]);
    v_total = VW'(v_live_q[0]) + VW'(v_live_q[1]) + VW'(v_live_q[2]) + VW'(v_live_q[3]);
    h_wrap   = HW'(hc_q) >= (h_total - HW'(1));
    v_wrap   = VW'(vc_q) >= (v_total - VW'(1));
    boundary = pix_en && h_wrap && v_wrap;

    if (pix_en) begin
      if (h_wrap) begin
        hc_d = '0;
        vc_d = v_wrap ? '0 : vc_q + V_BITS'(1);
      end else begin
        hc_d = hc_q + H_BITS'(1);
      end
    end

    // Live set samples shadow before any same-edge write lands
    if (boundary) begin
      h_live_d    = h_shd_q;
      v_live_d    = v_shd_q;
      frame_cnt_d = frame_cnt_q + FRAME_BITS'(1);
    end

    if (cfg_we) begin
      if (cfg_addr[2]) v_shd_d[cfg_addr[1:0]] = V_BITS'(cfg_data);
      else             h_shd_d[cfg_addr[1:0]] = H_BITS'(cfg_data);
    end

    if (boundary)    cfg_pending_d = cfg_we;
    else if (cfg_we) cfg_pending_d = 1'b1;
  end

  // Output decode from next-state position and geometry (zero latency)
  always_comb begin
    h_sync_lo = HW'(h_live_d[0]) + HW'(h_live_d[1]);
    h_sync_hi = h_sync_lo + HW'(h_live_d[2]);
    v_sync_lo = VW'(v_live_d[0]) + VW'(v_live_d[1]);
    v_sync_hi = v_sync_lo + VW'(v_live_d[2]);

    act_d = (hc_d < h_live_d[0]) && (vc_d < v_live_d[0]);
    x_d   = act_d ? hc_d : '0;
    y_d   = act_d ? vc_d : '0;
    hs_d  = ((HW'(hc_d) >= h_sync_lo) && (HW'(hc_d) < h_sync_hi)) ? HSYNC_POL : ~HSYNC_POL;
    vs_d  = ((VW'(vc_d) >= v_sync_lo) && (VW'(vc_d) < v_sync_hi)) ? VSYNC_POL : ~VSYNC_POL;
    ls_d  = (hc_d == '0);
    fs_d  = (hc_d == '0) && (vc_d == '0);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_live_q      <= {H_BITS'(H_BACK), H_BITS'(H_SYNC), H_BITS'(H_FRONT), H_BITS'(H_ACTIVE)};
      h_shd_q       <= {H_BITS'(H_BACK), H_BITS'(H_SYNC), H_BITS'(H_FRONT), H_BITS'(H_ACTIVE)};
      v_live_q      <= {V_BITS'(V_BACK), V_BITS'(V_SYNC), V_BITS'(V_FRONT), V_BITS'(V_ACTIVE)};
      v_shd_q       <= {V_BITS'(V_BACK), V_BITS'(V_SYNC), V_BITS'(V_FRONT), V_BITS'(V_ACTIVE)};
      hc_q          <= '0;
      vc_q          <= '0;
      cfg_pending_q <= 1'b0;
      frame_cnt_q   <= '0;
      x_q           <= '0;
      y_q           <= '0;
      act_q         <= ACT_RST;
      hs_q          <= ~HSYNC_POL;
      vs_q          <= ~VSYNC_POL;
      ls_q          <= 1'b1;
      fs_q          <= 1'b1;
    end else begin
      h_live_q      <= h_live_d;
      h_shd_q       <= h_shd_d;
      v_live_q      <= v_live_d;
      v_shd_q       <= v_shd_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      cfg_pending_q <= cfg_pending_d;
      frame_cnt_q   <= frame_cnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      act_q         <= act_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      ls_q          <= ls_d;
      fs_q          <= fs_d;
    end
  end

  // Delay line of {hsync, vsync, de}, advancing on pix_en steps only
  if (SYNC_DELAY == 0) begin : g_nodly
    assign hsync_d = hs_q;
    assign vsync_d = vs_q;
    assign de_d    = act_q;
  end else begin : g_dly
    logic [SYNC_DELAY-1:0][2:0] dly_q, dly_d;

    // Shift register next state
    always_comb begin
      dly_d = dly_q;
      if (pix_en) begin
        dly_d[0] = {hs_q, vs_q, act_q};
        for (int i = 1; i < SYNC_DELAY; i++) dly_d[i] = dly_q[i-1];
      end
    end

    // Shift register flops, reset to inactive sync and no DE
    always_ff @(posedge clk or posedge reset) begin
      if (reset) dly_q <= {SYNC_DELAY{~HSYNC_POL, ~VSYNC_POL, 1'b0}};
      else       dly_q <= dly_d;
    end

    assign hsync_d = dly_q[SYNC_DELAY-1][2];
    assign vsync_d = dly_q[SYNC_DELAY-1][1];
    assign de_d    = dly_q[SYNC_DELAY-1][0];
  end

  assign cfg_pending = cfg_pending_q;
  assign frame_cnt   = frame_cnt_q;
  assign x           = x_q;
  assign y           = y_q;
  assign in_frame    = act_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule

// File: doc/vga_timing_prog.md
Name: vga_timing_prog

Overview:
- Next-generation VGA/DVI timing generator with run-time programmable geometry, selectable sync polarity and a pixel-enable input for divided pixel clocks.
- Provides aligned pipeline-delayed sync/DE taps and frame/line markers.
- Sits between the system clock domain's pixel pipeline and the video PHY/DAC.
- Geometry is written through a small register port and applied atomically at frame boundaries, so there is no mid-frame tearing.

Parameters:
- H_BITS, 11, width of horizontal counter and x; each full line total must be < 2^H_BITS.
- V_BITS, 10, width of vertical counter and y; each full frame total must be < 2^V_BITS.
- CFG_BITS, 11, cfg_data width; must be >= max(H_BITS, V_BITS).
- H_ACTIVE/H_FRONT/H_SYNC/H_BACK, 800/40/128/88, reset values of the horizontal timing registers.
- V_ACTIVE/V_FRONT/V_SYNC/V_BACK, 600/1/4/23, reset values of the vertical timing registers.
- HSYNC_POL, 1, active level of hsync/hsync_d (1 = active-high).
- VSYNC_POL, 1, active level of vsync/vsync_d.
- SYNC_DELAY, 2, pix_en-qualified delay stages for hsync_d/vsync_d/de_d (0 allowed = pass-through).
- FRAME_BITS, 16, frame counter width.

Ports:
- clk  in  1  pixel/system clock
- reset  in  1  asynchronous, active-high reset
- pix_en  in  1  counter advance qualifier; tie 1 for full-rate
- cfg_we  in  1  shadow register write strobe
- cfg_addr  in  3  0..3 = H_ACTIVE/FRONT/SYNC/BACK, 4..7 = V_ACTIVE/FRONT/SYNC/BACK
- cfg_data  in  CFG_BITS  value written; truncated to H_BITS (addr 0-3) or V_BITS (addr 4-7)
- cfg_pending  out  1  shadow differs from live set, awaiting frame boundary
- x  out  H_BITS  horizontal position, 0 outside active area
- y  out  V_BITS  vertical position, 0 outside active area
- in_frame  out  1  hc < h_active && vc < v_active
- hsync  out  1  horizontal sync at HSYNC_POL
- vsync  out  1  vertical sync at VSYNC_POL
- line_start  out  1  hc == 0
- frame_start  out  1  hc == 0 && vc == 0
- hsync_d, vsync_d, de_d  out  1 each  hsync/vsync/in_frame delayed SYNC_DELAY pix_en steps
- frame_cnt  out  FRAME_BITS  completed frames, wraps

Behaviour:
- Live and shadow register sets.
  - h_total = h_active + h_front + h_sync + h_back; v_total likewise.
  - Arithmetic is done in H_BITS+1 / V_BITS+1 bits. Overflow of the field width is a configuration error; behaviour is undefined and not checked.
- Counter advance: only on clk edges with pix_en=1.
  - hc wraps at h_total-1 to 0.
  - vc increments when hc wraps, and wraps at v_total-1 to 0.
  - pix_en=0: every register and output holds.
- All outputs are flops. They always reflect the current hc/vc, because they are computed from next-state values, so there is zero latency between counter and outputs.
- Sync windows:
  - hsync active for h_active+h_front <= hc < h_active+h_front+h_sync.
  - vsync uses the same rule on vc.
  - Inactive level = ~POL.
  - h_sync=0 or v_sync=0 means that sync never asserts.
- Frame boundary: the advance from (h_total-1, v_total-1) to (0, 0).
  - On that edge the live set is loaded from shadow, cfg_pending clears, and frame_cnt increments (wrap at 2^FRAME_BITS).
  - The new geometry governs the first line of the new frame.
- cfg_we: writes shadow[cfg_addr] and sets cfg_pending the next cycle.
  - A write on the same edge as a frame boundary lands in shadow only: it is NOT applied, and cfg_pending stays 1 until the next boundary.
  - A write of a value equal to live still sets cfg_pending.
- cfg_pending and frame_cnt update on the boundary edge regardless of cfg_we timing; pix_en=0 blocks the boundary.
- Delay line: SYNC_DELAY-deep shift of {hsync, vsync, in_frame}, shifting only on pix_en.
  - Reset fills it with inactive sync levels and de=0.
  - SYNC_DELAY=0: the _d outputs equal the undelayed outputs.
- Reset (async assert, any time including mid-frame):
  - hc=vc=0, live=shadow=parameter defaults, cfg_pending=0, frame_cnt=0.
  - Outputs during and after reset: x=0, y=0, in_frame=1, line_start=1, frame_start=1, hsync=~HSYNC_POL, vsync=~VSYNC_POL, hsync_d=~HSYNC_POL, vsync_d=~VSYNC_POL, de_d=0.
- h_active=0 or v_active=0: in_frame is never 1, and x/y stay 0.

Test Plan:
- Defaults, pix_en=1, run 2 frames -> line period 1056 clks; hsync=1 for hc 840..967 (128 clks); vsync=1 for lines 601..604; frame period 663168 clks; frame_cnt=2.
- pix_en toggling 1/0 -> all waveforms stretched exactly 2x; outputs hold on pix_en=0 cycles; no extra transitions.
- Write H_ACTIVE=640, H_FRONT=16, H_SYNC=96, H_BACK=48 mid-frame -> cfg_pending=1, current frame still uses 1056-clk lines; after boundary lines are 800 clks, hsync hc 656..751, cfg_pending=0.
- cfg_we coincident with the boundary edge -> value not applied this frame, cfg_pending stays 1, applied one frame later.
- HSYNC_POL=0, SYNC_DELAY=3 -> hsync low during the sync window; hsync_d/de_d equal hsync/in_frame shifted 3 pix_en steps; after reset hsync_d=1, de_d=0 for the first 3 steps.
- Assert reset at hc=500, vc=300 after a pending write -> immediately x=0, y=0, frame_start=1, cfg_pending=0, geometry back to 800x600 defaults, frame_cnt=0.
